// File: rtl/wb_trace_buf.sv
// rtl/wb_trace_buf.sv - write-back trace capture FIFO with PC-triggered capture FSM
//
// Purpose:
//   Records retiring instructions as {pc, ir, wdata} entries in a circular FIFO.
//   A capture session is started by arm. It begins immediately, or when trig_pc
//   retires if trig_en is set. It ends after POST capture attempts.
//   The records are drained through a ready/valid read port.
//
// Ports:
//   clk, rstn                     clock, asynchronous active-low reset
//   wb_valid/wb_pc/wb_ir/wb_wdata write-back stage retirement
//   arm, trig_en, trig_pc         session control and trigger PC
//   cfg_wrap                      1 = overwrite oldest entry on overflow, 0 = drop new entry
//   clr                           synchronous clear, highest priority
//   rd_ready/rd_valid/rd_*        head-of-FIFO read port (combinational from storage)
//   count, full                   occupancy
//   state                         0 IDLE, 1 ARMED, 2 CAPTURE, 3 DONE
//   drop_cnt, retire_cnt          overflow losses (saturating), total retirements (wrapping)

module wb_trace_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int POST  = 8
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          wb_valid,
  input  logic [31:0]   wb_pc,
  input  logic [31:0]   wb_ir,
  input  logic [31:0]   wb_wdata,
  input  logic          arm,
  input  logic          trig_en,
  input  logic [31:0]   trig_pc,
  input  logic          cfg_wrap,
  input  logic          clr,
  input  logic          rd_ready,
  output logic          rd_valid,
  output logic [31:0]   rd_pc,
  output logic [31:0]   rd_ir,
  output logic [31:0]   rd_wdata,
  output logic [AW:0]   count,
  output logic          full,
  output logic [1:0]    state,
  output logic [15:0]   drop_cnt,
  output logic [31:0]   retire_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [15:0] POST_L  = 16'(POST);

  state_t        state_q, state_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic [15:0]   drop_q, drop_d;
  logic [31:0]   retire_q, retire_d;
  logic [15:0]   post_q, post_d;

  logic [31:0]   mem_pc    [DEPTH];
  logic [31:0]   mem_ir    [DEPTH];
  logic [31:0]   mem_wdata [DEPTH];

  logic          capture;
  logic          pop;
  logic          we;
  logic          empty;

  assign empty    = (count_q == '0);
  assign full     = (count_q == DEPTH_L);
  assign rd_valid = !empty;
  assign count    = count_q;
  assign state    = state_q;
  assign drop_cnt = drop_q;
  assign retire_cnt = retire_q;

  // The trigger retirement is captured in the same cycle it is recognised.
  assign capture = wb_valid &&
                   ((state_q == ST_CAPTURE) ||
                    ((state_q == ST_ARMED) && (wb_pc == trig_pc)));
  assign pop     = rd_valid && rd_ready;

  // Head is read straight from storage; zeros when empty so the port is quiet.
  assign rd_pc    = empty ? 32'd0 : mem_pc[rptr_q];
  assign rd_ir    = empty ? 32'd0 : mem_ir[rptr_q];
  assign rd_wdata = empty ? 32'd0 : mem_wdata[rptr_q];

  always_comb begin
    state_d  = state_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    count_d  = count_q;
    drop_d   = drop_q;
    post_d   = post_q;
    retire_d = wb_valid ? retire_q + 32'd1 : retire_q;
    we       = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (arm) begin
          state_d = trig_en ? ST_ARMED : ST_CAPTURE;
          post_d  = 16'd0;
        end
      end
      ST_ARMED, ST_CAPTURE: begin
        // Every attempt counts, stored or dropped; POST=1 can finish on the trigger itself.
        if (capture) begin
          post_d  = post_q + 16'd1;
          state_d = (post_d == POST_L) ? ST_DONE : ST_CAPTURE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (capture && pop) begin
      // Simultaneous push and pop never drops, even when full.
      we      = 1'b1;
      wptr_d  = wptr_q + 1'b1;
      rptr_d  = rptr_q + 1'b1;
    end else if (capture) begin
      if (!full) begin
        we      = 1'b1;
        wptr_d  = wptr_q + 1'b1;
        count_d = count_q + 1'b1;
      end else begin
        if (drop_q != 16'hFFFF) begin
          drop_d = drop_q + 16'd1;
        end
        // When full wptr equals rptr, so this write replaces the oldest entry.
        if (cfg_wrap) begin
          we     = 1'b1;
          wptr_d = wptr_q + 1'b1;
          rptr_d = rptr_q + 1'b1;
        end
      end
    end else if (pop) begin
      rptr_d  = rptr_q + 1'b1;
      count_d = count_q - 1'b1;
    end

    if (clr) begin
      state_d  = ST_IDLE;
      wptr_d   = '0;
      rptr_d   = '0;
      count_d  = '0;
      drop_d   = 16'd0;
      retire_d = 32'd0;
      post_d   = 16'd0;
      we       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      drop_q   <= 16'd0;
      retire_q <= 32'd0;
      post_q   <= 16'd0;
    end else begin
      state_q  <= state_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      drop_q   <= drop_d;
      retire_q <= retire_d;
      post_q   <= post_d;
    end
  end

  // Storage has no reset; entries are only visible through count.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_pc[wptr_q]    <= wb_pc;
      mem_ir[wptr_q]    <= wb_ir;
      mem_wdata[wptr_q] <= wb_wdata;
    end
  end

endmodule

// File: tb/tb_wb_trace_buf.sv
// tb/tb_wb_trace_buf.sv - directed self-checking bench for wb_trace_buf

module tb_wb_trace_buf;

  logic        clk = 1'b0;
  logic        rstn;
  logic        wb_valid;
  logic [31:0] wb_pc, wb_ir, wb_wdata;
  logic        arm, trig_en;
  logic [31:0] trig_pc;
  logic        cfg_wrap, clr, rd_ready;

  logic        a_rd_valid, b_rd_valid, c_rd_valid;
  logic [31:0] a_rd_pc, b_rd_pc, c_rd_pc;
  logic [31:0] a_rd_ir, b_rd_ir, c_rd_ir;
  logic [31:0] a_rd_wdata, b_rd_wdata, c_rd_wdata;
  logic [4:0]  a_count, b_count, c_count;
  logic        a_full, b_full, c_full;
  logic [1:0]  a_state, b_state, c_state;
  logic [15:0] a_drop, b_drop, c_drop;
  logic [31:0] a_ret, b_ret, c_ret;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  wb_trace_buf #(.DEPTH(16), .AW(4), .POST(8)) u_a (
    .clk(clk), .rstn(rstn), .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_ir(wb_ir),
    .wb_wdata(wb_wdata), .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc),
    .cfg_wrap(cfg_wrap), .clr(clr), .rd_ready(rd_ready), .rd_valid(a_rd_valid),
    .rd_pc(a_rd_pc), .rd_ir(a_rd_ir), .rd_wdata(a_rd_wdata), .count(a_count),
    .full(a_full), .state(a_state), .drop_cnt(a_drop), .retire_cnt(a_ret));

  wb_trace_buf #(.DEPTH(16), .AW(4), .POST(20)) u_b (
    .clk(clk), .rstn(rstn), .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_ir(wb_ir),
    .wb_wdata(wb_wdata), .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc),
    .cfg_wrap(cfg_wrap), .clr(clr), .rd_ready(rd_ready), .rd_valid(b_rd_valid),
    .rd_pc(b_rd_pc), .rd_ir(b_rd_ir), .rd_wdata(b_rd_wdata), .count(b_count),
    .full(b_full), .state(b_state), .drop_cnt(b_drop), .retire_cnt(b_ret));

  wb_trace_buf #(.DEPTH(16), .AW(4), .POST(40)) u_c (
    .clk(clk), .rstn(rstn), .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_ir(wb_ir),
    .wb_wdata(wb_wdata), .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc),
    .cfg_wrap(cfg_wrap), .clr(clr), .rd_ready(rd_ready), .rd_valid(c_rd_valid),
    .rd_pc(c_rd_pc), .rd_ir(c_rd_ir), .rd_wdata(c_rd_wdata), .count(c_count),
    .full(c_full), .state(c_state), .drop_cnt(c_drop), .retire_cnt(c_ret));

  // Inputs change 1 ns after the rising edge; outputs are sampled there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic retire(input logic [31:0] pc);
    wb_valid = 1'b1;
    wb_pc    = pc;
    wb_ir    = pc ^ 32'hA5A5_0000;
    wb_wdata = pc + 32'h0000_1000;
    step();
    wb_valid = 1'b0;
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; wb_valid = 1'b0; wb_pc = '0; wb_ir = '0; wb_wdata = '0;
    arm = 1'b0; trig_en = 1'b0; trig_pc = '0; cfg_wrap = 1'b0; clr = 1'b0; rd_ready = 1'b0;
    #12;
    nvec++; if ({a_rd_valid, a_full, a_state, a_count} !== 9'd0) begin nerr++; $display("FAIL reset_a_ctl got %h want 0", {a_rd_valid, a_full, a_state, a_count}); end
    nvec++; if ({a_rd_pc, a_rd_ir, a_rd_wdata, a_drop, a_ret} !== 144'd0) begin nerr++; $display("FAIL reset_a_data got nonzero"); end
    nvec++; if ({b_rd_valid, b_full, b_state, b_count} !== 9'd0) begin nerr++; $display("FAIL reset_b_ctl got %h want 0", {b_rd_valid, b_full, b_state, b_count}); end
    nvec++; if ({b_rd_pc, b_rd_ir, b_rd_wdata, b_drop, b_ret} !== 144'd0) begin nerr++; $display("FAIL reset_b_data got nonzero"); end
    nvec++; if ({c_rd_valid, c_full, c_state, c_count} !== 9'd0) begin nerr++; $display("FAIL reset_c_ctl got %h want 0", {c_rd_valid, c_full, c_state, c_count}); end
    nvec++; if ({c_rd_pc, c_rd_ir, c_rd_wdata, c_drop, c_ret} !== 144'd0) begin nerr++; $display("FAIL reset_c_data got nonzero"); end
    rstn = 1'b1;
  endtask

  task automatic test_capture_immediate();
    trig_en = 1'b0;
    pulse_arm();
    nvec++; if (a_state !== 2'd2) begin nerr++; $display("FAIL imm_state_capture got %0d want 2", a_state); end
    for (int i = 0; i < 8; i++) begin
      retire(32'(i * 4));
      if (i == 0) begin
        nvec++; if (a_rd_valid !== 1'b1 || a_rd_pc !== 32'h0) begin nerr++; $display("FAIL imm_first_visible got v=%b pc=%h want v=1 pc=0", a_rd_valid, a_rd_pc); end
      end
      if (i == 6) begin
        nvec++; if (a_state !== 2'd2) begin nerr++; $display("FAIL imm_state_before_done got %0d want 2", a_state); end
      end
    end
    nvec++; if (a_state !== 2'd3 || a_count !== 5'd8) begin nerr++; $display("FAIL imm_done got state=%0d count=%0d want 3/8", a_state, a_count); end
    retire(32'h20);
    retire(32'h24);
    nvec++; if (a_count !== 5'd8 || a_drop !== 16'd0) begin nerr++; $display("FAIL imm_no_capture_done got count=%0d drop=%0d want 8/0", a_count, a_drop); end
    nvec++; if (a_ret !== 32'd10) begin nerr++; $display("FAIL imm_retire_cnt got %0d want 10", a_ret); end
    rd_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      nvec++;
      if (a_rd_valid !== 1'b1 || a_rd_pc !== 32'(i * 4) ||
          a_rd_ir !== (32'(i * 4) ^ 32'hA5A5_0000) || a_rd_wdata !== (32'(i * 4) + 32'h1000)) begin
        nerr++; $display("FAIL imm_drain_%0d got v=%b pc=%h ir=%h wd=%h", i, a_rd_valid, a_rd_pc, a_rd_ir, a_rd_wdata);
      end
      step();
    end
    rd_ready = 1'b0;
    nvec++; if (a_rd_valid !== 1'b0 || a_count !== 5'd0 || a_rd_pc !== 32'd0) begin nerr++; $display("FAIL imm_empty got v=%b count=%0d pc=%h want 0/0/0", a_rd_valid, a_count, a_rd_pc); end
  endtask

  task automatic test_trigger();
    pulse_clr();
    trig_en = 1'b1;
    trig_pc = 32'h40;
    pulse_arm();
    nvec++; if (a_state !== 2'd1) begin nerr++; $display("FAIL trig_armed got %0d want 1", a_state); end
    retire(32'h30);
    retire(32'h34);
    nvec++; if (a_state !== 2'd1 || a_count !== 5'd0) begin nerr++; $display("FAIL trig_wait got state=%0d count=%0d want 1/0", a_state, a_count); end
    retire(32'h40);
    nvec++; if (a_state !== 2'd2 || a_count !== 5'd1 || a_rd_pc !== 32'h40) begin nerr++; $display("FAIL trig_hit got state=%0d count=%0d pc=%h want 2/1/40", a_state, a_count, a_rd_pc); end
    retire(32'h44);
    nvec++; if (a_count !== 5'd2 || a_rd_pc !== 32'h40 || a_ret !== 32'd4) begin nerr++; $display("FAIL trig_after got count=%0d pc=%h ret=%0d want 2/40/4", a_count, a_rd_pc, a_ret); end
    trig_en = 1'b0;
  endtask

  task automatic test_overflow_drop();
    pulse_clr();
    cfg_wrap = 1'b0;
    pulse_arm();
    for (int i = 0; i < 20; i++) retire(32'h100 + 32'(i * 4));
    nvec++; if (b_count !== 5'd16 || b_full !== 1'b1) begin nerr++; $display("FAIL drop_full got count=%0d full=%b want 16/1", b_count, b_full); end
    nvec++; if (b_drop !== 16'd4) begin nerr++; $display("FAIL drop_cnt got %0d want 4", b_drop); end
    nvec++; if (b_rd_pc !== 32'h100 || b_state !== 2'd3) begin nerr++; $display("FAIL drop_head got pc=%h state=%0d want 100/3", b_rd_pc, b_state); end
  endtask

  task automatic test_overflow_wrap();
    pulse_clr();
    cfg_wrap = 1'b1;
    pulse_arm();
    for (int i = 0; i < 20; i++) retire(32'h100 + 32'(i * 4));
    nvec++; if (b_count !== 5'd16 || b_drop !== 16'd4) begin nerr++; $display("FAIL wrap_cnt got count=%0d drop=%0d want 16/4", b_count, b_drop); end
    nvec++; if (b_rd_pc !== 32'h110) begin nerr++; $display("FAIL wrap_head got %h want 110", b_rd_pc); end
    rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      nvec++;
      if (b_rd_pc !== 32'h110 + 32'(i * 4) || b_rd_ir !== ((32'h110 + 32'(i * 4)) ^ 32'hA5A5_0000)) begin
        nerr++; $display("FAIL wrap_drain_%0d got pc=%h ir=%h want pc=%h", i, b_rd_pc, b_rd_ir, 32'h110 + 32'(i * 4));
      end
      step();
    end
    rd_ready = 1'b0;
    nvec++; if (b_rd_valid !== 1'b0) begin nerr++; $display("FAIL wrap_empty got %b want 0", b_rd_valid); end
    cfg_wrap = 1'b0;
  endtask

  task automatic test_back_to_back();
    pulse_clr();
    pulse_arm();
    for (int i = 0; i < 16; i++) retire(32'h200 + 32'(i * 4));
    nvec++; if (c_full !== 1'b1 || c_state !== 2'd2) begin nerr++; $display("FAIL b2b_pre got full=%b state=%0d want 1/2", c_full, c_state); end
    rd_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      nvec++; if (c_rd_pc !== 32'h200 + 32'(i * 4)) begin nerr++; $display("FAIL b2b_pop_%0d got %h want %h", i, c_rd_pc, 32'h200 + 32'(i * 4)); end
      retire(32'h240 + 32'(i * 4));
    end
    rd_ready = 1'b0;
    nvec++; if (c_count !== 5'd16 || c_drop !== 16'd0) begin nerr++; $display("FAIL b2b_cnt got count=%0d drop=%0d want 16/0", c_count, c_drop); end
    rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      nvec++;
      if (c_rd_pc !== 32'h214 + 32'(i * 4) || c_rd_wdata !== 32'h1214 + 32'(i * 4)) begin
        nerr++; $display("FAIL b2b_drain_%0d got pc=%h wd=%h want pc=%h", i, c_rd_pc, c_rd_wdata, 32'h214 + 32'(i * 4));
      end
      step();
    end
    rd_ready = 1'b0;
  endtask

  task automatic test_clr_priority();
    pulse_clr();
    pulse_arm();
    for (int i = 0; i < 5; i++) retire(32'h300 + 32'(i * 4));
    nvec++; if (c_count !== 5'd5 || c_state !== 2'd2) begin nerr++; $display("FAIL clr_pre got count=%0d state=%0d want 5/2", c_count, c_state); end
    clr = 1'b1; wb_valid = 1'b1; wb_pc = 32'h400; rd_ready = 1'b1;
    step();
    clr = 1'b0; wb_valid = 1'b0; rd_ready = 1'b0;
    nvec++; if (c_count !== 5'd0 || c_rd_valid !== 1'b0 || c_state !== 2'd0) begin nerr++; $display("FAIL clr_fifo got count=%0d v=%b state=%0d want 0/0/0", c_count, c_rd_valid, c_state); end
    nvec++; if (c_ret !== 32'd0 || c_drop !== 16'd0 || c_rd_pc !== 32'd0) begin nerr++; $display("FAIL clr_cnt got ret=%0d drop=%0d pc=%h want 0", c_ret, c_drop, c_rd_pc); end
  endtask

  task automatic test_async_reset();
    pulse_arm();
    for (int i = 0; i < 3; i++) retire(32'h500 + 32'(i * 4));
    nvec++; if (c_count !== 5'd3 || c_ret !== 32'd3) begin nerr++; $display("FAIL arst_pre got count=%0d ret=%0d want 3/3", c_count, c_ret); end
    #2;
    rstn = 1'b0;
    #1;
    nvec++; if ({c_rd_valid, c_full, c_state, c_count} !== 9'd0) begin nerr++; $display("FAIL arst_ctl got %h want 0", {c_rd_valid, c_full, c_state, c_count}); end
    nvec++; if (c_rd_pc !== 32'd0 || c_ret !== 32'd0 || c_drop !== 16'd0) begin nerr++; $display("FAIL arst_data got pc=%h ret=%0d drop=%0d want 0", c_rd_pc, c_ret, c_drop); end
    #2;
    rstn = 1'b1;
  endtask

  initial begin
    test_reset();
    test_capture_immediate();
    test_trigger();
    test_overflow_drop();
    test_overflow_wrap();
    test_back_to_back();
    test_clr_priority();
    test_async_reset();
    step();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
